tcp_ip_receiver: RTL and testbench
==================================

// Module: tcp_ip_receiver
// PURPOSE
// - RMII receive-side frame parser; the receive counterpart of the TCP/IP frame transmitter.
// - Takes 2-bit RMII receive data, finds the preamble and SFD, and assembles bytes.
// - Captures the MAC, IPv4 and TCP header words in the same 32-bit packing the transmitter consumes.
// - Streams payload as 32-bit words, checks the FCS and reports frame status to the packet layer.
// PARAMETERS
// MAX_FRAME_BYTES      1518  max bytes from dst MAC through FCS; more sets frame_err
// MIN_PREAMBLE_DIBITS  4     consecutive 2'b01 dibits required before SFD
// CHECK_FCS            1     1: CRC32 failure sets frame_err; 0: CRC ignored
// PORTS
// clk            in   1    RMII 50 MHz reference clock, one dibit per cycle
// rst            in   1    synchronous reset, active-high
// rx_d           in   2    RMII receive dibit
// crs_dv         in   1    RMII carrier sense / data valid
// mac_1,mac_2,mac_3 out 32 each  dst[47:16] | dst[15:0],src[47:32] | src[31:0]
// mac_length     out  16   EtherType/length field
// ip_w0..ip_w4   out  32 each  IPv4 header words 0..4, first byte in [31:24]
// tcp_w0..tcp_w5 out  32 each  TCP ports, seq, ack, param, csum/urg, options/padding
// hdr_valid      out  1    1-cycle pulse: all 58 header bytes captured
// data           out  32   payload word, first byte in [31:24]
// data_valid     out  1    1-cycle pulse per payload word
// data_last      out  1    with data_valid: final payload word
// data_count     out  11   payload byte count, valid with frame_done
// frame_done     out  1    1-cycle pulse at end of every frame that reached SFD
// frame_err      out  1    valid with frame_done: runt, oversize, odd dibit, or bad FCS
// busy           out  1    high whenever state != IDLE
// BEHAVIOUR
// - Reset values: every output 0; state IDLE; all counters and the CRC register cleared.
// - Reset mid-frame aborts immediately; no frame_done for the aborted frame.
// - Bit order: first dibit of a byte is byte[1:0]; the fourth dibit is byte[7:6].
// - Byte order: bytes complete in wire order.
// - FSM states: IDLE, PREAMBLE, HEADER, PAYLOAD, DRAIN.
// - IDLE -> PREAMBLE: crs_dv=1 and rx_d=01.
// - PREAMBLE:
//   - Counts 01 dibits.
//   - rx_d=11 with count >= MIN_PREAMBLE_DIBITS: SFD found -> HEADER.
//   - Byte counter and dibit phase cleared; CRC preset to 32'hFFFFFFFF.
//   - Any other dibit, or crs_dv=0: -> IDLE with no frame_done.
// - HEADER:
//   - Bytes 0..57 are shifted into the header registers: mac 0..13, ip 14..33, tcp 34..57.
//   - hdr_valid pulses the cycle after byte 57 completes; then -> PAYLOAD.
// - PAYLOAD:
//   - Bytes go through a 4-byte delay line so the trailing FCS is never emitted.
//   - A byte leaving the delay line is packed into the word assembler.
//   - The 4th packed byte gives data_valid on the next cycle.
// - End of frame:
//   - crs_dv=0 in HEADER or PAYLOAD -> DRAIN.
//   - DRAIN emits any partial word, zero-padded in the low bytes, with data_last=1.
//   - If the final word is full, data_last rides on that word instead.
//   - One cycle later frame_done pulses with data_count and frame_err; then -> IDLE.
// - CRC32:
//   - Reflected polynomial 32'hEDB88320 over every byte from dst MAC through FCS.
//   - Pass when the residue equals 32'hDEBB20E3.
// - frame_err=1 for any of:
//   - crs_dv fell on a non-byte boundary;
//   - total bytes < 62 (58 header + 4 FCS);
//   - bytes > MAX_FRAME_BYTES (reception stops counting, FSM waits for crs_dv=0);
//   - CHECK_FCS=1 and CRC failed.
// - Runt frame ending in HEADER: hdr_valid is not pulsed; frame_done/frame_err=1 still pulse.
// - data_count saturates at 2047.
// - crs_dv=1 arriving in the same cycle as the frame_done pulse is ignored; SFD search restarts in IDLE.
// TESTING
// - 62-byte frame, zero payload, good FCS -> hdr_valid once; no data_valid; frame_done=1, frame_err=0, data_count=0.
// - 70-byte frame with payload DEADBEEF 01 02 03 04 -> data 32'hDEADBEEF, then 32'h01020304 with data_last; data_count=8.
// - 65-byte frame, 3-byte payload AA BB CC -> single word 32'hAABBCC00 with data_last=1; data_count=3.
// - Good frame with one FCS bit flipped -> frame_err=1; same frame with CHECK_FCS=0 -> frame_err=0.
// - 40-byte runt -> no hdr_valid; frame_done=1, frame_err=1.
// - Preamble of only 3 dibits then 11 -> no SFD, busy returns to 0, no frame_done.
// - Odd-dibit end of frame -> frame_err=1.
// - rst asserted at byte 30 -> all outputs 0 next cycle; next good frame parses normally.

Source files
------------

// File: rtl/tcp_ip_receiver.sv
// RMII receive-side frame parser: hunts preamble/SFD, captures the 58-byte MAC/IPv4/TCP
// header, streams payload words with the trailing FCS stripped, and reports per-frame status.
module tcp_ip_receiver #(
  parameter int MAX_FRAME_BYTES     = 1518,
  parameter int MIN_PREAMBLE_DIBITS = 4,
  parameter bit CHECK_FCS           = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [1:0]  rx_d,
  input  logic        crs_dv,
  output logic [31:0] mac_1,
  output logic [31:0] mac_2,
  output logic [31:0] mac_3,
  output logic [15:0] mac_length,
  output logic [31:0] ip_w0,
  output logic [31:0] ip_w1,
  output logic [31:0] ip_w2,
  output logic [31:0] ip_w3,
  output logic [31:0] ip_w4,
  output logic [31:0] tcp_w0,
  output logic [31:0] tcp_w1,
  output logic [31:0] tcp_w2,
  output logic [31:0] tcp_w3,
  output logic [31:0] tcp_w4,
  output logic [31:0] tcp_w5,
  output logic        hdr_valid,
  output logic [31:0] data,
  output logic        data_valid,
  output logic        data_last,
  output logic [10:0] data_count,
  output logic        frame_done,
  output logic        frame_err,
  output logic        busy
);

  localparam int BCW       = $clog2(MAX_FRAME_BYTES + 2);
  localparam int PCW       = $clog2(MIN_PREAMBLE_DIBITS + 1);
  localparam int HDR_BYTES = 58;
  localparam logic [BCW-1:0] LAST_HDR    = BCW'(HDR_BYTES - 1);
  localparam logic [BCW-1:0] MIN_BYTES   = BCW'(HDR_BYTES + 4);
  localparam logic [BCW-1:0] MAX_BYTES   = BCW'(MAX_FRAME_BYTES);
  localparam logic [PCW-1:0] PRE_MIN     = PCW'(MIN_PREAMBLE_DIBITS);
  localparam logic [31:0]    CRC_POLY    = 32'hEDB88320;
  localparam logic [31:0]    CRC_RESIDUE = 32'hDEBB20E3;

  typedef enum logic [2:0] {IDLE, PREAMBLE, HEADER, PAYLOAD, DRAIN} state_t;

  state_t           state_q, state_d;
  logic [PCW-1:0]   pre_cnt_q, pre_cnt_d;
  logic [1:0]       phase_q, phase_d;
  logic [5:0]       sr_q, sr_d;
  logic [BCW-1:0]   byte_cnt_q, byte_cnt_d;
  logic             ovf_q, ovf_d;
  logic             odd_q, odd_d;
  logic [31:0]      crc_q, crc_d;
  logic [463:0]     hdr_q, hdr_d;
  logic [31:0]      dl_q, dl_d;
  logic [2:0]       dl_cnt_q, dl_cnt_d;
  logic [31:0]      word_q, word_d;
  logic [2:0]       wcnt_q, wcnt_d;
  logic [10:0]      pay_cnt_q, pay_cnt_d;
  logic             drain_step_q, drain_step_d;
  logic             hdr_valid_q, hdr_valid_d;
  logic [31:0]      data_q, data_d;
  logic             data_valid_q, data_valid_d;
  logic             data_last_q, data_last_d;
  logic [10:0]      data_count_q, data_count_d;
  logic             frame_done_q, frame_done_d;
  logic             frame_err_q, frame_err_d;
  logic             busy_q, busy_d;

  logic [7:0] byte_val;
  logic       byte_stb;

  function automatic logic [31:0] crc_byte(input logic [31:0] crc_in, input logic [7:0] b);
    logic [31:0] c;
    c = crc_in ^ {24'h0, b};
    for (int i = 0; i < 8; i++) c = c[0] ? ((c >> 1) ^ CRC_POLY) : (c >> 1);
    return c;
  endfunction

  // Dibits arrive LSB first, so the current dibit completes byte[7:6]
  assign byte_val = {rx_d, sr_q};
  assign byte_stb = ((state_q == HEADER) || (state_q == PAYLOAD)) && crs_dv &&
                    (phase_q == 2'd3) && !ovf_q;

  always_comb begin
    state_d      = state_q;
    pre_cnt_d    = pre_cnt_q;
    phase_d      = phase_q;
    sr_d         = sr_q;
    byte_cnt_d   = byte_cnt_q;
    ovf_d        = ovf_q;
    odd_d        = odd_q;
    crc_d        = crc_q;
    hdr_d        = hdr_q;
    dl_d         = dl_q;
    dl_cnt_d     = dl_cnt_q;
    word_d       = word_q;
    wcnt_d       = wcnt_q;
    pay_cnt_d    = pay_cnt_q;
    drain_step_d = drain_step_q;
    hdr_valid_d  = 1'b0;
    data_d       = data_q;
    data_valid_d = 1'b0;
    data_last_d  = 1'b0;
    data_count_d = '0;
    frame_done_d = 1'b0;
    frame_err_d  = 1'b0;

    case (state_q)
      IDLE: begin
        if (crs_dv && (rx_d == 2'b01) && !frame_done_q) begin
          state_d   = PREAMBLE;
          pre_cnt_d = PCW'(1);
        end
      end
      PREAMBLE: begin
        if (!crs_dv) begin
          state_d = IDLE;
        end else if (rx_d == 2'b01) begin
          if (pre_cnt_q < PRE_MIN) pre_cnt_d = pre_cnt_q + 1'b1;
        end else if ((rx_d == 2'b11) && (pre_cnt_q >= PRE_MIN)) begin
          state_d    = HEADER;
          phase_d    = '0;
          byte_cnt_d = '0;
          crc_d      = '1;
          ovf_d      = 1'b0;
          odd_d      = 1'b0;
          dl_cnt_d   = '0;
          wcnt_d     = '0;
          word_d     = '0;
          pay_cnt_d  = '0;
        end else begin
          state_d = IDLE;
        end
      end
      HEADER, PAYLOAD: begin
        // A full word is held one cycle so crs_dv can tell whether it is the last one
        if ((state_q == PAYLOAD) && (wcnt_q == 3'd4)) begin
          data_d       = word_q;
          data_valid_d = 1'b1;
          data_last_d  = !crs_dv;
          word_d       = '0;
          wcnt_d       = '0;
        end
        if (!crs_dv) begin
          odd_d        = (phase_q != 2'd0);
          drain_step_d = 1'b0;
          state_d      = DRAIN;
        end else begin
          phase_d = phase_q + 2'd1;
          sr_d    = {rx_d, sr_q[5:2]};
          if (byte_stb) begin
            if (byte_cnt_q == MAX_BYTES) begin
              ovf_d = 1'b1;
            end else begin
              byte_cnt_d = byte_cnt_q + 1'b1;
              crc_d      = crc_byte(crc_q, byte_val);
              if (state_q == HEADER) begin
                for (int k = 0; k < HDR_BYTES; k++)
                  if (byte_cnt_q == BCW'(k)) hdr_d[463 - 8*k -: 8] = byte_val;
                if (byte_cnt_q == LAST_HDR) begin
                  hdr_valid_d = 1'b1;
                  state_d     = PAYLOAD;
                end
              end else begin
                // Four-byte delay line keeps the FCS out of the payload stream
                dl_d = {dl_q[23:0], byte_val};
                if (dl_cnt_q == 3'd4) begin
                  for (int k = 0; k < 4; k++)
                    if (wcnt_q[1:0] == 2'(k)) word_d[31 - 8*k -: 8] = dl_q[31:24];
                  wcnt_d = wcnt_q + 3'd1;
                  if (pay_cnt_q != 11'h7FF) pay_cnt_d = pay_cnt_q + 11'd1;
                end else begin
                  dl_cnt_d = dl_cnt_q + 3'd1;
                end
              end
            end
          end
        end
      end
      DRAIN: begin
        if (!drain_step_q) begin
          if (wcnt_q != 3'd0) begin
            data_d       = word_q;
            data_valid_d = 1'b1;
            data_last_d  = 1'b1;
            word_d       = '0;
            wcnt_d       = '0;
          end
          drain_step_d = 1'b1;
        end else begin
          frame_done_d = 1'b1;
          data_count_d = pay_cnt_q;
          frame_err_d  = odd_q || ovf_q || (byte_cnt_q < MIN_BYTES) ||
                         (CHECK_FCS && (crc_q != CRC_RESIDUE));
          state_d      = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      pre_cnt_q    <= '0;
      phase_q      <= '0;
      sr_q         <= '0;
      byte_cnt_q   <= '0;
      ovf_q        <= 1'b0;
      odd_q        <= 1'b0;
      crc_q        <= '0;
      hdr_q        <= '0;
      dl_q         <= '0;
      dl_cnt_q     <= '0;
      word_q       <= '0;
      wcnt_q       <= '0;
      pay_cnt_q    <= '0;
      drain_step_q <= 1'b0;
      hdr_valid_q  <= 1'b0;
      data_q       <= '0;
      data_valid_q <= 1'b0;
      data_last_q  <= 1'b0;
      data_count_q <= '0;
      frame_done_q <= 1'b0;
      frame_err_q  <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      pre_cnt_q    <= pre_cnt_d;
      phase_q      <= phase_d;
      sr_q         <= sr_d;
      byte_cnt_q   <= byte_cnt_d;
      ovf_q        <= ovf_d;
      odd_q        <= odd_d;
      crc_q        <= crc_d;
      hdr_q        <= hdr_d;
      dl_q         <= dl_d;
      dl_cnt_q     <= dl_cnt_d;
      word_q       <= word_d;
      wcnt_q       <= wcnt_d;
      pay_cnt_q    <= pay_cnt_d;
      drain_step_q <= drain_step_d;
      hdr_valid_q  <= hdr_valid_d;
      data_q       <= data_d;
      data_valid_q <= data_valid_d;
      data_last_q  <= data_last_d;
      data_count_q <= data_count_d;
      frame_done_q <= frame_done_d;
      frame_err_q  <= frame_err_d;
      busy_q       <= busy_d;
    end
  end

  assign mac_1      = hdr_q[463:432];
  assign mac_2      = hdr_q[431:400];
  assign mac_3      = hdr_q[399:368];
  assign mac_length = hdr_q[367:352];
  assign ip_w0      = hdr_q[351:320];
  assign ip_w1      = hdr_q[319:288];
  assign ip_w2      = hdr_q[287:256];
  assign ip_w3      = hdr_q[255:224];
  assign ip_w4      = hdr_q[223:192];
  assign tcp_w0     = hdr_q[191:160];
  assign tcp_w1     = hdr_q[159:128];
  assign tcp_w2     = hdr_q[127:96];
  assign tcp_w3     = hdr_q[95:64];
  assign tcp_w4     = hdr_q[63:32];
  assign tcp_w5     = hdr_q[31:0];
  assign hdr_valid  = hdr_valid_q;
  assign data       = data_q;
  assign data_valid = data_valid_q;
  assign data_last  = data_last_q;
  assign data_count = data_count_q;
  assign frame_done = frame_done_q;
  assign frame_err  = frame_err_q;
  assign busy       = busy_q;

endmodule

// File: tb/tb_tcp_ip_receiver.sv
// Scoreboard bench for tcp_ip_receiver: directed RMII frames, expected words/status queued
// at stimulus time and popped by monitors on the DUT output pulses.
module tb_tcp_ip_receiver;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  rx_d;
  logic        crs_dv;

  logic [31:0] mac_1, mac_2, mac_3, ip_w0, ip_w1, ip_w2, ip_w3, ip_w4;
  logic [31:0] tcp_w0, tcp_w1, tcp_w2, tcp_w3, tcp_w4, tcp_w5, data;
  logic [15:0] mac_length;
  logic        hdr_valid, data_valid, data_last, frame_done, frame_err, busy;
  logic [10:0] data_count;

  logic [31:0] u2Mac1, u2Mac2, u2Mac3, u2Ip0, u2Ip1, u2Ip2, u2Ip3, u2Ip4;
  logic [31:0] u2Tcp0, u2Tcp1, u2Tcp2, u2Tcp3, u2Tcp4, u2Tcp5, u2Data;
  logic [15:0] u2MacLength;
  logic        u2HdrValid, u2DataValid, u2DataLast, u2FrameDone, u2FrameErr, u2Busy;
  logic [10:0] u2DataCount;

  typedef struct {
    logic [31:0] word;
    logic        last;
  } expWord_t;

  typedef struct {
    logic [10:0] count;
    logic        err;
  } expRes_t;

  expWord_t    expWords[$];
  expRes_t     expRes[$];
  expRes_t     expRes2[$];
  int          hdrPending = 0;
  logic [7:0]  txQ[$];
  logic [7:0]  payQ[$];
  int          total = 0;
  int          bad = 0;

  always #10 clk = ~clk;

  tcp_ip_receiver #(.MAX_FRAME_BYTES(1518), .MIN_PREAMBLE_DIBITS(4), .CHECK_FCS(1'b1)) dut (
    .clk(clk), .rst(rst), .rx_d(rx_d), .crs_dv(crs_dv),
    .mac_1(mac_1), .mac_2(mac_2), .mac_3(mac_3), .mac_length(mac_length),
    .ip_w0(ip_w0), .ip_w1(ip_w1), .ip_w2(ip_w2), .ip_w3(ip_w3), .ip_w4(ip_w4),
    .tcp_w0(tcp_w0), .tcp_w1(tcp_w1), .tcp_w2(tcp_w2), .tcp_w3(tcp_w3),
    .tcp_w4(tcp_w4), .tcp_w5(tcp_w5),
    .hdr_valid(hdr_valid), .data(data), .data_valid(data_valid), .data_last(data_last),
    .data_count(data_count), .frame_done(frame_done), .frame_err(frame_err), .busy(busy)
  );

  tcp_ip_receiver #(.MAX_FRAME_BYTES(1518), .MIN_PREAMBLE_DIBITS(4), .CHECK_FCS(1'b0)) dutNoFcs (
    .clk(clk), .rst(rst), .rx_d(rx_d), .crs_dv(crs_dv),
    .mac_1(u2Mac1), .mac_2(u2Mac2), .mac_3(u2Mac3), .mac_length(u2MacLength),
    .ip_w0(u2Ip0), .ip_w1(u2Ip1), .ip_w2(u2Ip2), .ip_w3(u2Ip3), .ip_w4(u2Ip4),
    .tcp_w0(u2Tcp0), .tcp_w1(u2Tcp1), .tcp_w2(u2Tcp2), .tcp_w3(u2Tcp3),
    .tcp_w4(u2Tcp4), .tcp_w5(u2Tcp5),
    .hdr_valid(u2HdrValid), .data(u2Data), .data_valid(u2DataValid), .data_last(u2DataLast),
    .data_count(u2DataCount), .frame_done(u2FrameDone), .frame_err(u2FrameErr), .busy(u2Busy)
  );

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got %h expected %h", name, actual, expected);
    end
  endtask

  function automatic logic [31:0] crcByte(input logic [31:0] c, input logic [7:0] b);
    logic [31:0] r;
    r = c ^ {24'h0, b};
    for (int i = 0; i < 8; i++) r = r[0] ? ((r >> 1) ^ 32'hEDB88320) : (r >> 1);
    return r;
  endfunction

  function automatic logic anyOut();
    return |{mac_1, mac_2, mac_3, mac_length, ip_w0, ip_w1, ip_w2, ip_w3, ip_w4,
             tcp_w0, tcp_w1, tcp_w2, tcp_w3, tcp_w4, tcp_w5, hdr_valid, data,
             data_valid, data_last, data_count, frame_done, frame_err, busy};
  endfunction

  // Header byte k carries value k; payload from payQ; FCS appended LSB byte first
  task automatic buildFrame(input int nHdr, input bit addFcs, input bit flipFcs);
    logic [31:0] c;
    txQ.delete();
    for (int k = 0; k < nHdr; k++) txQ.push_back(8'(k));
    foreach (payQ[k]) txQ.push_back(payQ[k]);
    if (addFcs) begin
      c = 32'hFFFFFFFF;
      foreach (txQ[k]) c = crcByte(c, txQ[k]);
      c = ~c;
      if (flipFcs) c[3] = ~c[3];
      for (int k = 0; k < 4; k++) txQ.push_back(c[8*k +: 8]);
    end
  endtask

  task automatic sendDibit(input logic [1:0] d);
    @(negedge clk);
    crs_dv = 1'b1;
    rx_d   = d;
  endtask

  task automatic sendByte(input logic [7:0] b);
    for (int i = 0; i < 4; i++) sendDibit(b[2*i +: 2]);
  endtask

  task automatic pushRes(input logic [10:0] count, input logic err, input logic errNoFcs);
    expRes.push_back('{count: count, err: err});
    expRes2.push_back('{count: count, err: errNoFcs});
  endtask

  task automatic pushWord(input logic [31:0] w, input logic last);
    expWords.push_back('{word: w, last: last});
  endtask

  // Sends preamble, SFD and txQ; optional trailing odd dibit; optional reset at byte abortAt
  task automatic applyStimulus(input bit extraDibit, input int abortAt);
    for (int k = 0; k < 7; k++) sendByte(8'h55);
    sendByte(8'hD5);
    foreach (txQ[k]) begin
      if (k == abortAt) begin
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        checkOutput("reset_mid_frame_outputs", 32'(anyOut()), 32'd0);
        rst    = 1'b0;
        crs_dv = 1'b0;
        rx_d   = 2'b00;
        return;
      end
      sendByte(txQ[k]);
    end
    if (extraDibit) sendDibit(2'b01);
    @(negedge clk);
    crs_dv = 1'b0;
    rx_d   = 2'b00;
  endtask

  task automatic waitIdle();
    int n;
    n = 0;
    while ((expRes.size() != 0 || expRes2.size() != 0 || expWords.size() != 0 ||
            hdrPending != 0) && n < 200) begin
      @(negedge clk);
      n++;
    end
    repeat (4) @(negedge clk);
    checkOutput("pending_words", 32'(expWords.size()), 32'd0);
    checkOutput("pending_status", 32'(expRes.size()), 32'd0);
    checkOutput("pending_status_nofcs", 32'(expRes2.size()), 32'd0);
    checkOutput("pending_hdr", 32'(hdrPending), 32'd0);
    checkOutput("busy_after_frame", 32'(busy), 32'd0);
  endtask

  // Monitor for the FCS-checking instance: header, payload words and frame status
  always @(negedge clk) begin
    expWord_t ew;
    expRes_t  er;
    if (hdr_valid) begin
      checkOutput("hdr_valid_expected", 32'(hdr_valid), (hdrPending > 0) ? 32'd1 : 32'd0);
      if (hdrPending > 0) begin
        hdrPending--;
        checkOutput("mac_1", mac_1, 32'h00010203);
        checkOutput("mac_2", mac_2, 32'h04050607);
        checkOutput("mac_3", mac_3, 32'h08090A0B);
        checkOutput("mac_length", 32'(mac_length), 32'h00000C0D);
        checkOutput("ip_w0", ip_w0, 32'h0E0F1011);
        checkOutput("ip_w1", ip_w1, 32'h12131415);
        checkOutput("ip_w2", ip_w2, 32'h16171819);
        checkOutput("ip_w3", ip_w3, 32'h1A1B1C1D);
        checkOutput("ip_w4", ip_w4, 32'h1E1F2021);
        checkOutput("tcp_w0", tcp_w0, 32'h22232425);
        checkOutput("tcp_w1", tcp_w1, 32'h26272829);
        checkOutput("tcp_w2", tcp_w2, 32'h2A2B2C2D);
        checkOutput("tcp_w3", tcp_w3, 32'h2E2F3031);
        checkOutput("tcp_w4", tcp_w4, 32'h32333435);
        checkOutput("tcp_w5", tcp_w5, 32'h36373839);
      end
    end
    if (data_valid) begin
      if (expWords.size() == 0) begin
        checkOutput("data_valid_unexpected", 32'(data_valid), 32'd0);
      end else begin
        ew = expWords.pop_front();
        checkOutput("data_word", data, ew.word);
        checkOutput("data_last", 32'(data_last), 32'(ew.last));
      end
    end
    if (frame_done) begin
      if (expRes.size() == 0) begin
        checkOutput("frame_done_unexpected", 32'(frame_done), 32'd0);
      end else begin
        er = expRes.pop_front();
        checkOutput("data_count", 32'(data_count), 32'(er.count));
        checkOutput("frame_err", 32'(frame_err), 32'(er.err));
      end
    end
  end

  // Monitor for the instance that ignores the FCS
  always @(negedge clk) begin
    expRes_t er;
    if (u2FrameDone) begin
      if (expRes2.size() == 0) begin
        checkOutput("nofcs_frame_done_unexpected", 32'(u2FrameDone), 32'd0);
      end else begin
        er = expRes2.pop_front();
        checkOutput("nofcs_data_count", 32'(u2DataCount), 32'(er.count));
        checkOutput("nofcs_frame_err", 32'(u2FrameErr), 32'(er.err));
      end
    end
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst    = 1'b1;
    rx_d   = 2'b00;
    crs_dv = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("reset_outputs", 32'(anyOut()), 32'd0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    $display("[TB] 62-byte frame, empty payload");
    payQ.delete();
    buildFrame(58, 1'b1, 1'b0);
    hdrPending++;
    pushRes(11'd0, 1'b0, 1'b0);
    applyStimulus(1'b0, -1);
    waitIdle();

    $display("[TB] 70-byte frame, two payload words");
    payQ = '{8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'h01, 8'h02, 8'h03, 8'h04};
    buildFrame(58, 1'b1, 1'b0);
    hdrPending++;
    pushWord(32'hDEADBEEF, 1'b0);
    pushWord(32'h01020304, 1'b1);
    pushRes(11'd8, 1'b0, 1'b0);
    applyStimulus(1'b0, -1);
    waitIdle();

    $display("[TB] 65-byte frame, partial payload word");
    payQ = '{8'hAA, 8'hBB, 8'hCC};
    buildFrame(58, 1'b1, 1'b0);
    hdrPending++;
    pushWord(32'hAABBCC00, 1'b1);
    pushRes(11'd3, 1'b0, 1'b0);
    applyStimulus(1'b0, -1);
    waitIdle();

    $display("[TB] 70-byte frame with one FCS bit flipped");
    payQ = '{8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'h01, 8'h02, 8'h03, 8'h04};
    buildFrame(58, 1'b1, 1'b1);
    hdrPending++;
    pushWord(32'hDEADBEEF, 1'b0);
    pushWord(32'h01020304, 1'b1);
    pushRes(11'd8, 1'b1, 1'b0);
    applyStimulus(1'b0, -1);
    waitIdle();

    $display("[TB] 40-byte runt");
    payQ.delete();
    buildFrame(40, 1'b0, 1'b0);
    pushRes(11'd0, 1'b1, 1'b1);
    applyStimulus(1'b0, -1);
    waitIdle();

    $display("[TB] short preamble");
    for (int i = 0; i < 3; i++) sendDibit(2'b01);
    @(negedge clk);
    checkOutput("busy_in_preamble", 32'(busy), 32'd1);
    crs_dv = 1'b1;
    rx_d   = 2'b11;
    @(negedge clk);
    checkOutput("busy_after_short_preamble", 32'(busy), 32'd0);
    crs_dv = 1'b0;
    rx_d   = 2'b00;
    waitIdle();

    $display("[TB] odd dibit at end of frame");
    payQ = '{8'h5A};
    buildFrame(58, 1'b1, 1'b0);
    hdrPending++;
    pushWord(32'h5A000000, 1'b1);
    pushRes(11'd1, 1'b1, 1'b1);
    applyStimulus(1'b1, -1);
    waitIdle();

    $display("[TB] reset at byte 30, then a good frame");
    payQ.delete();
    buildFrame(58, 1'b1, 1'b0);
    applyStimulus(1'b0, 30);
    waitIdle();
    payQ = '{8'hAA, 8'hBB, 8'hCC};
    buildFrame(58, 1'b1, 1'b0);
    hdrPending++;
    pushWord(32'hAABBCC00, 1'b1);
    pushRes(11'd3, 1'b0, 1'b0);
    applyStimulus(1'b0, -1);
    waitIdle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
